// File: rtl/light_sequencer_pkg.sv
// Shared definitions for the traffic-light sequencer: lamp codes, phase states,
// cycle wrap limits and phase-boundary counter values.
package light_sequencer_pkg;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    typedef enum logic [2:0] {
        MAIN_G, MAIN_Y, ALL_R1, SIDE_G, SIDE_Y, ALL_R2, WALK
    } state_t;

    localparam logic [5:0] WRAP_NOPED = 6'd30;
    localparam logic [5:0] WRAP_PED   = 6'd40;

    // Counter value at the tick that leaves each phase.
    localparam logic [5:0] BND_MAIN_G = 6'd11;
    localparam logic [5:0] BND_MAIN_Y = 6'd13;
    localparam logic [5:0] BND_ALL_R1 = 6'd15;
    localparam logic [5:0] BND_SIDE_G = 6'd26;
    localparam logic [5:0] BND_SIDE_Y = 6'd28;
    localparam logic [5:0] BND_ALL_R2 = 6'd30;
    localparam logic [5:0] BND_WALK   = 6'd40;

    function automatic state_t next_state(input state_t s, input logic ped);
        case (s)
            MAIN_G:  next_state = MAIN_Y;
            MAIN_Y:  next_state = ALL_R1;
            ALL_R1:  next_state = SIDE_G;
            SIDE_G:  next_state = SIDE_Y;
            SIDE_Y:  next_state = ALL_R2;
            ALL_R2:  next_state = ped ? WALK : MAIN_G;
            default: next_state = MAIN_G;
        endcase
    endfunction

    function automatic logic [2:0] main_lamp(input state_t s);
        case (s)
            MAIN_G:  main_lamp = LAMP_G;
            MAIN_Y:  main_lamp = LAMP_Y;
            default: main_lamp = LAMP_R;
        endcase
    endfunction

    function automatic logic [2:0] side_lamp(input state_t s);
        case (s)
            SIDE_G:  side_lamp = LAMP_G;
            SIDE_Y:  side_lamp = LAMP_Y;
            default: side_lamp = LAMP_R;
        endcase
    endfunction

endpackage

// File: rtl/light_sequencer_ped_sync.sv
// Two-flop synchroniser for the raw pedestrian button plus rising-edge detect.
module ped_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ped_btn,
    output logic rise
);

    logic r_s1, r_s2, r_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= ped_btn;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign rise = r_s2 & ~r_s3;

endmodule

// File: rtl/light_sequencer.sv
// Traffic-light phase sequencer: tick-driven cycle counter, phase FSM with
// registered lamp outputs, and a per-cycle pedestrian walk request latch.
module light_sequencer
    import light_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       ped_btn,
    input  logic       enable,
    output logic [5:0] counter,
    output logic       PED,
    output logic [2:0] mainTraffic,
    output logic [2:0] sideTraffic,
    output logic       walk
);

    state_t     r_state;
    logic [5:0] r_counter;
    logic       r_ped, r_pending, r_walk;
    logic [2:0] r_main, r_side;

    logic       w_rise, w_wrap;
    logic [5:0] w_limit;
    state_t     w_nxt_state;

    ped_sync u_ped_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .ped_btn (ped_btn),
        .rise    (w_rise)
    );

    // >= also catches a corrupted counter beyond the limit.
    always_comb begin
        w_limit     = r_ped ? WRAP_PED : WRAP_NOPED;
        w_wrap      = (r_counter >= w_limit);
        w_nxt_state = r_state;
        if (w_wrap)
            w_nxt_state = MAIN_G;
        else if (enable)
            w_nxt_state = next_state(r_state, r_ped);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= MAIN_G;
            r_counter <= 6'd0;
            r_main    <= LAMP_G;
            r_side    <= LAMP_R;
            r_walk    <= 1'b0;
        end else if (tick) begin
            r_state   <= w_nxt_state;
            r_counter <= w_wrap ? 6'd0 : r_counter + 6'd1;
            r_main    <= main_lamp(w_nxt_state);
            r_side    <= side_lamp(w_nxt_state);
            r_walk    <= (w_nxt_state == WALK);
        end
    end

    // A request is held until the next wrap; extra edges meanwhile are absorbed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ped     <= 1'b0;
            r_pending <= 1'b0;
        end else if (tick && w_wrap) begin
            r_ped     <= r_pending | w_rise;
            r_pending <= 1'b0;
        end else if (w_rise) begin
            r_pending <= 1'b1;
        end
    end

    assign counter     = r_counter;
    assign PED         = r_ped;
    assign mainTraffic = r_main;
    assign sideTraffic = r_side;
    assign walk        = r_walk;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer with an external phase-boundary enable model.
module tb_light_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, tick, ped_btn, enable;
    logic [5:0] counter;
    logic       PED, walk;
    logic [2:0] mainTraffic, sideTraffic;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    light_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .ped_btn     (ped_btn),
        .enable      (enable),
        .counter     (counter),
        .PED         (PED),
        .mainTraffic (mainTraffic),
        .sideTraffic (sideTraffic),
        .walk        (walk)
    );

    // Downstream timing stage stand-in: qualify the advance at each phase end.
    assign enable = (counter == 6'd11) || (counter == 6'd13) || (counter == 6'd15) ||
                    (counter == 6'd26) || (counter == 6'd28) || (counter == 6'd30) ||
                    (counter == 6'd40);

    always @(negedge clk) begin
        total++;
        assert ($onehot(mainTraffic) && $onehot(sideTraffic))
        else begin
            bad++;
            $error("FAIL onehot: main=%b side=%b required one-hot", mainTraffic, sideTraffic);
        end
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d required=%0d", tag, got, exp);
        end
    endtask

    task automatic step_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic pulse();
        ped_btn = 1'b1;
        repeat (4) @(negedge clk);
        ped_btn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [2:0] exp_main(input int c);
        if (c <= 11) return 3'b001;
        if (c <= 13) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] exp_side(input int c);
        if (c >= 16 && c <= 26) return 3'b001;
        if (c >= 27 && c <= 28) return 3'b010;
        return 3'b100;
    endfunction

    // Walk one full cycle from counter 0, checking every position, pulsing where asked.
    task automatic run_cycle(input logic ped, input logic [63:0] pmask);
        int lim;
        lim = ped ? 40 : 30;
        for (int c = 0; c <= lim; c++) begin
            chk("counter", 8'(counter), 8'(c));
            chk("PED", 8'(PED), 8'(ped));
            chk("main", 8'(mainTraffic), 8'(exp_main(c)));
            chk("side", 8'(sideTraffic), 8'(exp_side(c)));
            chk("walk", 8'(walk), 8'(c >= 31));
            if (pmask[c]) pulse();
            step_tick();
        end
        chk("wrap_counter", 8'(counter), 8'd0);
    endtask

    initial begin
        logic [63:0] m;
        rst_n = 1'b0; tick = 1'b0; ped_btn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_counter", 8'(counter), 8'd0);
        chk("rst_main", 8'(mainTraffic), 8'b001);
        chk("rst_side", 8'(sideTraffic), 8'b100);
        chk("rst_walk", 8'(walk), 8'd0);
        chk("rst_PED", 8'(PED), 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_cycle(1'b0, 64'd0);
        m = 64'd0; m[5] = 1'b1;
        run_cycle(1'b0, m);
        m = 64'd0; m[35] = 1'b1;
        run_cycle(1'b1, m);
        run_cycle(1'b1, 64'd0);
        m = 64'd0; m[3] = 1'b1; m[10] = 1'b1; m[20] = 1'b1;
        run_cycle(1'b0, m);
        run_cycle(1'b1, 64'd0);
        run_cycle(1'b0, 64'd0);

        // Long tick-low hold in MAIN_Y.
        repeat (12) step_tick();
        repeat (100) @(negedge clk);
        chk("hold_counter", 8'(counter), 8'd12);
        chk("hold_main", 8'(mainTraffic), 8'b010);
        chk("hold_side", 8'(sideTraffic), 8'b100);
        chk("hold_walk", 8'(walk), 8'd0);

        // Asynchronous reset in SIDE_G, asserted between clock edges.
        repeat (8) step_tick();
        chk("pre_rst_counter", 8'(counter), 8'd20);
        chk("pre_rst_side", 8'(sideTraffic), 8'b001);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_counter", 8'(counter), 8'd0);
        chk("arst_main", 8'(mainTraffic), 8'b001);
        chk("arst_side", 8'(sideTraffic), 8'b100);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step_tick();
        chk("post_rst_counter", 8'(counter), 8'd1);
        chk("post_rst_main", 8'(mainTraffic), 8'b001);

        // Back-to-back ticks advance once per clock.
        tick = 1'b1;
        repeat (3) @(negedge clk);
        tick = 1'b0;
        chk("b2b_counter", 8'(counter), 8'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
